// File: rtl/bsg_manycore_network_cfg_ctrl.sv
// rtl/bsg_manycore_network_cfg_ctrl.sv - runtime network cfg code switch controller
module bsg_manycore_network_cfg_ctrl #(
  parameter int                    lg_max_cfgs_p    = 7,
  parameter int                    num_cfgs_p       = 5,
  parameter logic [num_cfgs_p-1:0] supported_mask_p = '1,
  parameter int                    reset_cfg_p      = 1,
  parameter int                    num_links_p      = 4,
  parameter int                    settle_cycles_p  = 8,
  parameter int                    drain_timeout_p  = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  input  logic [lg_max_cfgs_p-1:0] req_cfg_i,
  output logic                     req_ready_o,
  input  logic [num_links_p-1:0]   links_idle_i,
  output logic                     quiesce_o,
  output logic [lg_max_cfgs_p-1:0] cfg_o,
  output logic                     cfg_v_o,
  output logic                     done_v_o,
  output logic [1:0]               done_err_o
);

  localparam int cnt_max_lp = (drain_timeout_p > settle_cycles_p) ? drain_timeout_p : settle_cycles_p;
  localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);
  localparam int full_w_lp  = 1 << lg_max_cfgs_p;

  localparam logic [1:0] err_ok_lp          = 2'd0;
  localparam logic [1:0] err_unsupported_lp = 2'd1;
  localparam logic [1:0] err_timeout_lp     = 2'd2;

  // Parameter sanity: counters and drain detection need these minimums.
  if (settle_cycles_p < 1) begin : g_bad_settle
    $error("settle_cycles_p must be >= 1");
  end
  if (drain_timeout_p < 3) begin : g_bad_timeout
    $error("drain_timeout_p must be >= 3");
  end
  if ((reset_cfg_p >= num_cfgs_p) || (((supported_mask_p >> reset_cfg_p) & 1) == 0)) begin : g_bad_reset_cfg
    $error("reset_cfg_p must be a supported code");
  end

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_drain  = 2'd1,
    st_switch = 2'd2,
    st_settle = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_max_cfgs_p-1:0] cfg_q, cfg_d;
  logic [lg_max_cfgs_p-1:0] target_q, target_d;
  logic                     cfg_v_q, cfg_v_d;
  logic                     quiesce_q, quiesce_d;
  logic                     done_v_q, done_v_d;
  logic [1:0]               done_err_q, done_err_d;
  logic [1:0]               stable_q, stable_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;

  // Mask widened to cover every encodable code; codes past num_cfgs_p read as unsupported.
  logic [full_w_lp-1:0] mask_full;
  logic                 req_in_range;
  logic                 req_supported;
  logic                 all_idle;

  assign mask_full     = full_w_lp'(supported_mask_p);
  assign req_in_range  = ({1'b0, req_cfg_i} < (lg_max_cfgs_p + 1)'(num_cfgs_p));
  assign req_supported = req_in_range & mask_full[req_cfg_i];
  assign all_idle      = &links_idle_i;

  assign req_ready_o = (state_q == st_idle);
  assign quiesce_o   = quiesce_q;
  assign cfg_o       = cfg_q;
  assign cfg_v_o     = cfg_v_q;
  assign done_v_o    = done_v_q;
  assign done_err_o  = done_err_q;

  // Next-state and registered-output decisions for the switch sequence.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    target_d   = target_q;
    cfg_v_d    = cfg_v_q;
    quiesce_d  = quiesce_q;
    done_v_d   = 1'b0;
    done_err_d = done_err_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      st_idle: begin
        if (req_v_i) begin
          if (!req_supported) begin
            done_v_d   = 1'b1;
            done_err_d = err_unsupported_lp;
          end else if (req_cfg_i == cfg_q) begin
            done_v_d   = 1'b1;
            done_err_d = err_ok_lp;
          end else begin
            target_d  = req_cfg_i;
            state_d   = st_drain;
            quiesce_d = 1'b1;
            cfg_v_d   = 1'b0;
            stable_d  = '0;
            cnt_d     = '0;
          end
        end
      end

      st_drain: begin
        cnt_d    = cnt_q + cnt_w_lp'(1);
        stable_d = all_idle ? (stable_q + 2'd1) : 2'd0;
        // Second consecutive idle cycle beats a coincident timeout.
        if (all_idle && (stable_q == 2'd1)) begin
          state_d = st_switch;
        end else if (cnt_q == cnt_w_lp'(drain_timeout_p - 1)) begin
          state_d    = st_idle;
          quiesce_d  = 1'b0;
          cfg_v_d    = 1'b1;
          done_v_d   = 1'b1;
          done_err_d = err_timeout_lp;
        end
      end

      st_switch: begin
        cfg_d   = target_q;
        cnt_d   = '0;
        state_d = st_settle;
      end

      st_settle: begin
        cnt_d = cnt_q + cnt_w_lp'(1);
        if (cnt_q == cnt_w_lp'(settle_cycles_p - 1)) begin
          state_d    = st_idle;
          quiesce_d  = 1'b0;
          cfg_v_d    = 1'b1;
          done_v_d   = 1'b1;
          done_err_d = err_ok_lp;
        end
      end

      default: begin
        state_d = st_idle;
      end
    endcase
  end

  // State and output registers; reset restores the build's default code.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= st_idle;
      cfg_q      <= lg_max_cfgs_p'(reset_cfg_p);
      target_q   <= '0;
      cfg_v_q    <= 1'b1;
      quiesce_q  <= 1'b0;
      done_v_q   <= 1'b0;
      done_err_q <= 2'd0;
      stable_q   <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      target_q   <= target_d;
      cfg_v_q    <= cfg_v_d;
      quiesce_q  <= quiesce_d;
      done_v_q   <= done_v_d;
      done_err_q <= done_err_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_network_cfg_ctrl.sv
// tb/tb_bsg_manycore_network_cfg_ctrl.sv - bench for bsg_manycore_network_cfg_ctrl
module tb_bsg_manycore_network_cfg_ctrl;

  localparam logic [4:0] mask_a = 5'b10111;
  localparam logic [4:0] mask_b = 5'b11111;
  localparam int settle_a = 8;
  localparam int settle_b = 3;
  localparam int tmo_a    = 1024;
  localparam int tmo_b    = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       sel = 1'b0;
  logic       req_v = 1'b0;
  logic [6:0] req_cfg = '0;
  logic [3:0] links = 4'hf;

  logic       ready_a, quiesce_a, cfg_v_a, done_a;
  logic [6:0] cfg_a;
  logic [1:0] err_ao;
  logic       ready_b, quiesce_b, cfg_v_b, done_b;
  logic [6:0] cfg_b;
  logic [1:0] err_bo;

  logic [12:0] obs;

  int checks = 0;
  int failures = 0;

  logic [6:0] cur_a, cur_b;
  logic [1:0] err_a, err_b;
  logic [3:0] pat [0:63];
  logic [3:0] pat_tail;

  always #5 clk = ~clk;

  bsg_manycore_network_cfg_ctrl #(
    .lg_max_cfgs_p(7), .num_cfgs_p(5), .supported_mask_p(mask_a), .reset_cfg_p(1),
    .num_links_p(4), .settle_cycles_p(settle_a), .drain_timeout_p(tmo_a)
  ) u_dut_a (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v & ~sel), .req_cfg_i(req_cfg),
    .req_ready_o(ready_a), .links_idle_i(links), .quiesce_o(quiesce_a), .cfg_o(cfg_a),
    .cfg_v_o(cfg_v_a), .done_v_o(done_a), .done_err_o(err_ao)
  );

  bsg_manycore_network_cfg_ctrl #(
    .lg_max_cfgs_p(7), .num_cfgs_p(5), .supported_mask_p(mask_b), .reset_cfg_p(1),
    .num_links_p(4), .settle_cycles_p(settle_b), .drain_timeout_p(tmo_b)
  ) u_dut_b (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v & sel), .req_cfg_i(req_cfg),
    .req_ready_o(ready_b), .links_idle_i(links), .quiesce_o(quiesce_b), .cfg_o(cfg_b),
    .cfg_v_o(cfg_v_b), .done_v_o(done_b), .done_err_o(err_bo)
  );

  assign obs = sel ? {ready_b, quiesce_b, cfg_v_b, done_b, err_bo, cfg_b}
                   : {ready_a, quiesce_a, cfg_v_a, done_a, err_ao, cfg_a};

  function automatic logic [3:0] pat_at(input int k);
    return (k < 64) ? pat[k] : pat_tail;
  endfunction

  // Transaction-level expectation: classify the request, find the first pair of
  // consecutive all-idle DRAIN cycles, then check every cycle of the outcome.
  task automatic run_req(input int s, input logic [6:0] c, input logic [3:0] tail_v, input string name);
    logic [6:0]  cur;
    logic [1:0]  eprev, eres;
    logic [4:0]  m;
    logic [12:0] exp;
    int S, T, kind, sw, E;
    cur   = (s != 0) ? cur_b : cur_a;
    eprev = (s != 0) ? err_b : err_a;
    m     = (s != 0) ? mask_b : mask_a;
    S     = (s != 0) ? settle_b : settle_a;
    T     = (s != 0) ? tmo_b : tmo_a;
    pat_tail = tail_v;
    sw = 0;
    if (c >= 7'd5 || !m[c[2:0]]) begin
      kind = 0; E = 1; eres = 2'd1;
    end else if (c == cur) begin
      kind = 1; E = 1; eres = 2'd0;
    end else begin
      for (int k = 2; k <= T; k++)
        if (sw == 0 && (&pat_at(k - 1)) && (&pat_at(k))) sw = k + 1;
      if (sw != 0) begin kind = 2; E = sw + 1 + S; eres = 2'd0; end
      else begin kind = 3; E = T + 1; eres = 2'd2; end
    end
    sel = (s != 0);
    for (int k = 0; k <= E + 1; k++) begin
      @(negedge clk);
      if (k == 0)
        exp = {3'b101, 1'b0, eprev, cur};
      else if (k < E)
        exp = {3'b010, 1'b0, eprev, (kind == 2 && k > sw) ? c : cur};
      else
        exp = {3'b101, (k == E), eres, (kind == 2) ? c : cur};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s k=%0d got{rdy,q,v,done,err,cfg}=%b exp=%b", name, k, obs, exp);
      end
      req_v   = (k == 0);
      req_cfg = c;
      links   = pat_at(k);
    end
    req_v = 1'b0;
    if (s != 0) begin
      err_b = eres; if (kind == 2) cur_b = c;
    end else begin
      err_a = eres; if (kind == 2) cur_a = c;
    end
  endtask

  task automatic fill_pat(input logic [3:0] v);
    for (int k = 0; k < 64; k++) pat[k] = v;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    reset_i = 1'b0;
    cur_a = 7'd1; cur_b = 7'd1; err_a = 2'd0; err_b = 2'd0;
    @(negedge clk);
    sel = 1'b0; #1;
    checks++;
    if (obs !== {3'b101, 1'b0, 2'd0, 7'd1}) begin
      failures++; $display("FAIL reset_a got=%b exp=%b", obs, {3'b101, 1'b0, 2'd0, 7'd1});
    end
    sel = 1'b1; #1;
    checks++;
    if (obs !== {3'b101, 1'b0, 2'd0, 7'd1}) begin
      failures++; $display("FAIL reset_b got=%b exp=%b", obs, {3'b101, 1'b0, 2'd0, 7'd1});
    end
  endtask

  task automatic test_switch_idle();
    fill_pat(4'hf);
    run_req(0, 7'd4, 4'hf, "switch_idle");
  endtask

  task automatic test_unsupported();
    fill_pat(4'hf);
    run_req(0, 7'd3, 4'hf, "masked_code");
    run_req(0, 7'd7, 4'hf, "out_of_range");
  endtask

  task automatic test_back_to_back();
    logic [6:0] codes [0:3];
    logic [1:0] errs  [0:3];
    logic [12:0] exp;
    codes[0] = 7'd3; codes[1] = cur_a; codes[2] = 7'd100; codes[3] = cur_a;
    errs[0]  = 2'd1; errs[1]  = 2'd0;  errs[2]  = 2'd1;   errs[3]  = 2'd0;
    sel = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) exp = {3'b101, 1'b0, err_a, cur_a};
      else        exp = {3'b101, (k <= 4), errs[(k <= 4) ? k - 1 : 3], cur_a};
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp);
      end
      req_v   = (k < 4);
      req_cfg = codes[(k < 4) ? k : 3];
    end
    req_v = 1'b0;
    err_a = 2'd0;
  endtask

  task automatic test_drain_busy();
    for (int k = 0; k < 64; k++) pat[k] = (k < 20) ? 4'b1011 : 4'hf;
    run_req(0, 7'd0, 4'hf, "drain_busy");
  endtask

  task automatic test_timeout();
    fill_pat(4'b1011);
    run_req(1, 7'd4, 4'b1011, "drain_timeout");
  endtask

  task automatic test_noop_and_glitch();
    fill_pat(4'hf);
    run_req(0, cur_a, 4'hf, "noop");
    pat[2] = 4'b0111;
    run_req(0, (cur_a == 7'd4) ? 7'd2 : 7'd4, 4'hf, "idle_glitch");
  endtask

  task automatic test_reset_mid_settle();
    logic [6:0] c;
    c = (cur_a == 7'd2) ? 7'd4 : 7'd2;
    sel = 1'b0; links = 4'hf;
    @(negedge clk);
    req_v = 1'b1; req_cfg = c;
    @(negedge clk);
    req_v = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (obs !== {3'b010, 1'b0, err_a, c}) begin
      failures++; $display("FAIL pre_reset_settle got=%b exp=%b", obs, {3'b010, 1'b0, err_a, c});
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (obs !== {3'b101, 1'b0, 2'd0, 7'd1}) begin
      failures++; $display("FAIL reset_mid_settle got=%b exp=%b", obs, {3'b101, 1'b0, 2'd0, 7'd1});
    end
    @(negedge clk);
    reset_i = 1'b0;
    cur_a = 7'd1; cur_b = 7'd1; err_a = 2'd0; err_b = 2'd0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== {3'b101, 1'b0, 2'd0, 7'd1}) begin
        failures++; $display("FAIL post_reset_idle got=%b exp=%b", obs, {3'b101, 1'b0, 2'd0, 7'd1});
      end
    end
  endtask

  task automatic test_random();
    int s;
    int p;
    logic [3:0] tail_v;
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 1);
      p = $urandom_range(0, 1) ? 3 : 1;
      for (int k = 0; k < 64; k++)
        pat[k] = ($urandom_range(0, 3) < p) ? 4'hf : 4'($urandom_range(0, 14));
      tail_v = (s != 0 && $urandom_range(0, 1) != 0) ? 4'b1110 : 4'hf;
      run_req(s, 7'($urandom_range(0, 7)), tail_v, "random");
    end
  endtask

  initial begin
    test_reset();
    test_switch_idle();
    test_unsupported();
    test_back_to_back();
    test_drain_busy();
    test_timeout();
    test_noop_and_glitch();
    test_reset_mid_settle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
